// File: rtl/mem_access.sv
// MEM stage: byte-serial load/store over an 8-bit synchronous RAM port,
// stalling the pipeline while an access is in flight; other ops pass straight through.
`ifndef RegBus
`define RegBus     31:0
`endif
`ifndef RegAddrBus
`define RegAddrBus 4:0
`endif
`ifndef OptBus
`define OptBus     4:0
`endif
`ifndef OpcodeBus
`define OpcodeBus  6:0
`endif
`ifndef OptLB
`define OptLB   5'd1
`define OptLH   5'd2
`define OptLW   5'd3
`define OptLBU  5'd4
`define OptLHU  5'd5
`define OptSB   5'd6
`define OptSH   5'd7
`define OptSW   5'd8
`define OptADDI 5'd9
`endif

module mem_access (
  input  logic               clk,
  input  logic               rst,
  input  logic [`OpcodeBus]  opcode_i,
  input  logic [`OptBus]     opt_i,
  input  logic               we_i,
  input  logic [`RegAddrBus] waddr_i,
  input  logic [`RegBus]     alu_i,
  input  logic [`RegBus]     rdata2_i,
  input  logic [7:0]         mem_din_i,
  output logic [`RegBus]     mem_a_o,
  output logic [7:0]         mem_dout_o,
  output logic               mem_wr_o,
  output logic               stall_o,
  output logic               we_o,
  output logic [`RegAddrBus] waddr_o,
  output logic [`RegBus]     wdata_o
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state;
  logic [1:0]  cnt;
  logic [31:0] ld_buf;

  logic        is_ld, is_st, is_mem;
  logic [2:0]  nbytes;
  logic [1:0]  last_idx, cap_idx;
  logic        issue;
  logic [31:0] ld_ext;

  logic unused_opcode;
  assign unused_opcode = ^opcode_i;

  always_comb begin
    is_ld  = 1'b0;
    is_st  = 1'b0;
    nbytes = 3'd0;
    case (opt_i)
      `OptLB, `OptLBU: begin is_ld = 1'b1; nbytes = 3'd1; end
      `OptLH, `OptLHU: begin is_ld = 1'b1; nbytes = 3'd2; end
      `OptLW:          begin is_ld = 1'b1; nbytes = 3'd4; end
      `OptSB:          begin is_st = 1'b1; nbytes = 3'd1; end
      `OptSH:          begin is_st = 1'b1; nbytes = 3'd2; end
      `OptSW:          begin is_st = 1'b1; nbytes = 3'd4; end
      default: ;
    endcase
  end

  assign is_mem   = is_ld | is_st;
  assign last_idx = nbytes[1:0] - 2'd1;
  assign cap_idx  = cnt - 2'd1;
  // cnt wraps to 0 after byte 3, so a word load's final capture phase shows up as cnt==0
  assign issue    = is_st | (cnt != nbytes[1:0]);

  always_comb begin
    case (opt_i)
      `OptLB:  ld_ext = {{24{ld_buf[7]}}, ld_buf[7:0]};
      `OptLBU: ld_ext = {24'd0, ld_buf[7:0]};
      `OptLH:  ld_ext = {{16{ld_buf[15]}}, ld_buf[15:0]};
      `OptLHU: ld_ext = {16'd0, ld_buf[15:0]};
      default: ld_ext = ld_buf;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= 2'd0;
      ld_buf <= 32'd0;
    end else begin
      case (state)
        IDLE: if (is_mem) begin
          cnt   <= 2'd1;
          state <= (is_st && nbytes == 3'd1) ? DONE : BUSY;
        end
        BUSY: begin
          if (!is_mem) begin
            state <= IDLE;
          end else begin
            if (is_ld) ld_buf[{cap_idx, 3'b000} +: 8] <= mem_din_i;
            if (issue) cnt <= cnt + 2'd1;
            if (is_ld ? !issue : (cnt == last_idx)) state <= DONE;
          end
        end
        DONE: begin
          cnt   <= 2'd0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Gated by rst so an in-flight write is cut off the moment reset asserts
  always_comb begin
    mem_a_o    = 32'd0;
    mem_dout_o = 8'd0;
    mem_wr_o   = 1'b0;
    stall_o    = 1'b0;
    we_o       = 1'b0;
    waddr_o    = 5'd0;
    wdata_o    = 32'd0;
    if (rst) begin
      case (state)
        IDLE: begin
          if (is_mem) begin
            stall_o = 1'b1;
            mem_a_o = alu_i;
            if (is_st) begin
              mem_wr_o   = 1'b1;
              mem_dout_o = rdata2_i[7:0];
            end
          end else begin
            we_o    = we_i;
            waddr_o = waddr_i;
            wdata_o = alu_i;
          end
        end
        BUSY: begin
          stall_o = 1'b1;
          if (is_mem && issue) begin
            mem_a_o = alu_i + {30'd0, cnt};
            if (is_st) begin
              mem_wr_o   = 1'b1;
              mem_dout_o = rdata2_i[{cnt, 3'b000} +: 8];
            end
          end
        end
        DONE: begin
          waddr_o = waddr_i;
          if (is_ld) begin
            we_o    = we_i;
            wdata_o = ld_ext;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
